// File: rtl/adc_arbiter_pkg.sv
// Shared ADC constants: FSM state encodings, timeout default and field widths
// used by the ADC arbiter and any other arbiter built on rr_select.
package adc_arbiter_pkg;

    localparam int ADC_TIMEOUT_DEFAULT = 4095;
    localparam int ADC_CNT_W           = 12;
    localparam int ADC_CMD_W           = 4;
    localparam int ADC_DATA_W          = 13;

    // Result reported when a transaction is aborted by the timeout.
    localparam logic [ADC_DATA_W-1:0] ADC_ABORT_RESULT = 13'h1FFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DELIVER   = 3'd4
    } arb_state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_arbiter_rr_select.sv
// Round-robin winner selection: the search starts one past the last-served
// index and wraps at NUM_REQ. Purely combinational, reusable by any arbiter.
module rr_select
    import adc_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner
);

    // One extra bit so last + offset cannot overflow before the wrap.
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    // Walk the requesters in priority order and keep the first one asserted.
    always_comb begin
        logic [PTR_W:0] idx;
        logic           found;
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last} + (PTR_W + 1)'(k);
            if (idx >= NUM_REQ_W) begin
                idx = idx - NUM_REQ_W;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                winner[idx[PTR_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_arbiter.sv
// Arbiter granting NUM_REQ requesters round-robin access to one serial ADC
// exchange engine. Each grant runs one start/ack/done exchange, then pulses
// Done to the granted requester. A wait phase longer than TIMEOUT cycles
// aborts with an all-ones result and raises the sticky TimeoutErr flag.
module adc_arbiter
    import adc_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = ADC_TIMEOUT_DEFAULT
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            Req,
    input  logic [NUM_REQ*ADC_CMD_W-1:0]  Cmd,
    output logic [NUM_REQ-1:0]            Gnt,
    output logic [NUM_REQ-1:0]            Done,
    output logic [ADC_DATA_W-1:0]         Result,
    output logic                          TimeoutErr,
    input  logic                          ErrClr,
    output logic                          ExStart,
    output logic [ADC_CMD_W-1:0]          ExDataIn,
    input  logic [ADC_DATA_W-1:0]         ExDataOut,
    input  logic                          ExBusy
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    // The wait counter reads n-1 in the n-th cycle of a phase, so this value
    // marks the TIMEOUT-th cycle spent waiting.
    localparam logic [ADC_CNT_W-1:0] WAIT_LAST = ADC_CNT_W'(TIMEOUT - 1);

    arb_state_t             state;
    logic [PTR_W-1:0]       last_served;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       win_idx;
    logic [NUM_REQ-1:0]     winner;
    logic [ADC_CNT_W-1:0]   wait_cnt;

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req    (Req),
        .last   (last_served),
        .winner (winner)
    );

    // Binary index of the one-hot winner, used to pick its command slice.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Arbitration and exchange sequencing; every output is a register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            Gnt         <= '0;
            Done        <= '0;
            ExStart     <= 1'b0;
            ExDataIn    <= '0;
            Result      <= '0;
            TimeoutErr  <= 1'b0;
            last_served <= PTR_W'(NUM_REQ - 1);
            gnt_idx     <= '0;
            wait_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees start-of-cycle values.
            ExStart <= 1'b0;
            Done    <= '0;
            // A timeout set later in this cycle overrides the clear.
            if (ErrClr) begin
                TimeoutErr <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (|Req) begin
                        Gnt      <= winner;
                        gnt_idx  <= win_idx;
                        ExDataIn <= Cmd[{win_idx, 2'b00} +: ADC_CMD_W];
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    ExStart  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    if (ExBusy) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Result     <= ADC_ABORT_RESULT;
                        TimeoutErr <= 1'b1;
                        Done       <= Gnt;
                        state      <= ST_DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!ExBusy) begin
                        Result <= ExDataOut;
                        Done   <= Gnt;
                        state  <= ST_DELIVER;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Result     <= ADC_ABORT_RESULT;
                        TimeoutErr <= 1'b1;
                        Done       <= Gnt;
                        state      <= ST_DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_DELIVER: begin
                    Gnt         <= '0;
                    last_served <= gnt_idx;
                    state       <= ST_IDLE;
                end

                default: begin
                    Gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_arbiter.sv
// Self-checking bench for adc_arbiter: a directed table of transactions,
// hand-written corner sequences and a randomized phase against a reference
// model of the round-robin and timing rules, with an ADC engine model.
`timescale 1ns/1ps
module tb_adc_arbiter;

    localparam int N = 3;
    localparam int T = 40;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [N-1:0]     Req;
    logic [N*4-1:0]   Cmd;
    logic [N-1:0]     Gnt;
    logic [N-1:0]     Done;
    logic [12:0]      Result;
    logic             TimeoutErr;
    logic             ErrClr;
    logic             ExStart;
    logic [3:0]       ExDataIn;
    logic [12:0]      ExDataOut;
    logic             ExBusy;

    adc_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (T)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req        (Req),
        .Cmd        (Cmd),
        .Gnt        (Gnt),
        .Done       (Done),
        .Result     (Result),
        .TimeoutErr (TimeoutErr),
        .ErrClr     (ErrClr),
        .ExStart    (ExStart),
        .ExDataIn   (ExDataIn),
        .ExDataOut  (ExDataOut),
        .ExBusy     (ExBusy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- exchange engine model ----------------
    int          eng_d = 0;
    int          eng_l = 1;
    bit          eng_never = 1'b0;
    logic [12:0] eng_data = '0;

    initial begin
        ExBusy    = 1'b0;
        ExDataOut = '0;
        forever begin
            @(negedge Clk);
            if (!Reset && ExStart && !eng_never) begin
                ExDataOut = ~eng_data;
                for (int k = 0; k < eng_d && !Reset; k++) @(negedge Clk);
                if (!Reset) begin
                    ExBusy = 1'b1;
                    for (int k = 0; k < eng_l && !Reset; k++) @(negedge Clk);
                    ExBusy = 1'b0;
                    if (!Reset) ExDataOut = eng_data;
                end else begin
                    ExBusy = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Cycles from the ExStart cycle to the Done cycle.
    function automatic int gap_of(input int d, input int l, input bit never);
        int ack;
        ack = never ? T + 1 : d + 1;
        if (ack > T) return T;
        return ack + ((l > T) ? T : l);
    endfunction

    function automatic bit aborts(input int d, input int l, input bit never);
        return never || (d + 1 > T) || (l > T);
    endfunction

    // Follows one transaction from arbitration to its Done pulse.
    task automatic observe(input string name, input int idx, input logic [3:0] cmd,
                           input int gap, input logic [12:0] res, input logic err,
                           input int drop_at, output int start_at);
        int         starts = 0;
        bit         done_seen = 1'b0;
        bit         din_moved = 1'b0;
        logic [3:0] din = '0;
        start_at = -1;
        for (int k = 0; k < 400 && !done_seen; k++) begin
            @(negedge Clk);
            if (ExStart) begin
                starts++;
                if (start_at < 0) begin
                    start_at = cyc;
                    din      = ExDataIn;
                    check({name, ".exdatain"}, 32'(ExDataIn), 32'(cmd));
                    check({name, ".gnt"}, 32'(Gnt), 32'(1) << idx);
                    Cmd = 12'($urandom);
                end
            end
            if (start_at >= 0 && ExDataIn !== din) din_moved = 1'b1;
            if (drop_at >= 0 && start_at >= 0 && cyc == start_at + drop_at) Req[idx] = 1'b0;
            if (Done !== '0) begin
                done_seen = 1'b1;
                check({name, ".done"}, 32'(Done), 32'(1) << idx);
                check({name, ".gnt_at_done"}, 32'(Gnt), 32'(1) << idx);
                check({name, ".result"}, 32'(Result), 32'(res));
                check({name, ".timeout_err"}, 32'(TimeoutErr), 32'(err));
                check({name, ".gap"}, 32'(cyc - start_at), 32'(gap));
                check({name, ".starts"}, 32'(starts), 32'd1);
                check({name, ".exdatain_held"}, 32'(din_moved), 32'd0);
            end
        end
        check({name, ".done_seen"}, 32'(done_seen), 32'd1);
    endtask

    // The cycle after Done: back in IDLE with no grant and no second pulse.
    task automatic idle_gap(input string name);
        @(negedge Clk);
        check({name, ".idle_gnt"}, 32'(Gnt), 32'd0);
        check({name, ".idle_done"}, 32'(Done), 32'd0);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           idx;
        int           d;
        int           l;
        bit           never;
        logic [12:0]  data;
        logic         err;
        int           drop_at;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sa;
        int req_at;
        int m_last;
        bit m_err;
        int idx;
        bit found;
        int done_cnt;

        Req    = '0;
        Cmd    = '0;
        ErrClr = 1'b0;

        tbl[0]  = '{3'b111, 0, 0, 3,     1'b0, 13'h0011, 1'b0, -1};
        tbl[1]  = '{3'b111, 1, 2, 1,     1'b0, 13'h1F00, 1'b0, -1};
        tbl[2]  = '{3'b111, 2, 1, 5,     1'b0, 13'h0555, 1'b0, -1};
        tbl[3]  = '{3'b111, 0, 0, 1,     1'b0, 13'h1AAA, 1'b0, -1};
        tbl[4]  = '{3'b100, 2, 3, 2,     1'b0, 13'h0123, 1'b0, -1};
        tbl[5]  = '{3'b101, 0, 0, 4,     1'b0, 13'h1234, 1'b0, -1};
        tbl[6]  = '{3'b101, 2, 1, 1,     1'b0, 13'h0FED, 1'b0, -1};
        tbl[7]  = '{3'b110, 1, 0, 12,    1'b0, 13'h0777, 1'b0, 4};
        tbl[8]  = '{3'b101, 2, 0, 2,     1'b0, 13'h1001, 1'b0, -1};
        tbl[9]  = '{3'b010, 1, T - 1, T, 1'b0, 13'h0BEE, 1'b0, -1};
        tbl[10] = '{3'b001, 0, 0, 1,     1'b1, 13'h0000, 1'b1, -1};
        tbl[11] = '{3'b010, 1, 0, T + 5, 1'b0, 13'h0333, 1'b1, -1};

        // Reset state.
        repeat (3) @(negedge Clk);
        check("rst.gnt", 32'(Gnt), 32'd0);
        check("rst.done", 32'(Done), 32'd0);
        check("rst.exstart", 32'(ExStart), 32'd0);
        check("rst.exdatain", 32'(ExDataIn), 32'd0);
        check("rst.result", 32'(Result), 32'd0);
        check("rst.timeout_err", 32'(TimeoutErr), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Single request: latency, command, data.
        eng_d = 1; eng_l = 30; eng_never = 1'b0; eng_data = 13'h0ABC;
        Cmd    = 12'h005;
        Req    = 3'b001;
        req_at = cyc;
        observe("single", 0, 4'h5, gap_of(1, 30, 1'b0), 13'h0ABC, 1'b0, -1, sa);
        check("single.latency", 32'(sa - req_at), 32'd2);
        Req = '0;
        idle_gap("single");

        // Directed table: contention, wrap, request drop, boundaries, timeouts.
        pulse_reset();
        for (int r = 0; r < NV; r++) begin
            string nm;
            nm        = $sformatf("vec%0d", r);
            Req       = tbl[r].req;
            Cmd       = 12'($urandom);
            eng_d     = tbl[r].d;
            eng_l     = tbl[r].l;
            eng_never = tbl[r].never;
            eng_data  = tbl[r].data;
            observe(nm, tbl[r].idx, Cmd[4*tbl[r].idx +: 4],
                    gap_of(tbl[r].d, tbl[r].l, tbl[r].never),
                    aborts(tbl[r].d, tbl[r].l, tbl[r].never) ? 13'h1FFF : tbl[r].data,
                    tbl[r].err, tbl[r].drop_at, sa);
            idle_gap(nm);
        end
        Req = '0;
        repeat (10) @(negedge Clk);

        // Sticky error, then ErrClr.
        check("err.sticky", 32'(TimeoutErr), 32'd1);
        ErrClr = 1'b1;
        @(negedge Clk);
        ErrClr = 1'b0;
        check("err.cleared", 32'(TimeoutErr), 32'd0);

        // Timeout set in the same cycle as ErrClr: set wins, clear follows.
        ErrClr    = 1'b1;
        eng_never = 1'b1;
        Req       = 3'b100;
        observe("setwins", 2, Cmd[11:8], T, 13'h1FFF, 1'b1, -1, sa);
        Req = '0;
        @(negedge Clk);
        check("setwins.cleared_after", 32'(TimeoutErr), 32'd0);
        ErrClr = 1'b0;

        // Reset while in WAIT_DONE: everything cleared, no Done.
        eng_never = 1'b0; eng_d = 0; eng_l = 20; eng_data = 13'h0CAF;
        Req   = 3'b001;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge Clk);
            if (ExStart) found = 1'b1;
        end
        check("rstmid.exstart_seen", 32'(found), 32'd1);
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("rstmid.gnt", 32'(Gnt), 32'd0);
        check("rstmid.done", 32'(Done), 32'd0);
        check("rstmid.exstart", 32'(ExStart), 32'd0);
        check("rstmid.exdatain", 32'(ExDataIn), 32'd0);
        check("rstmid.result", 32'(Result), 32'd0);
        check("rstmid.timeout_err", 32'(TimeoutErr), 32'd0);
        Reset = 1'b0;
        Req   = '0;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (Done !== '0) done_cnt++;
        end
        check("rstmid.no_done", 32'(done_cnt), 32'd0);

        // Pointer is back at NUM_REQ-1: requester 0 wins a full contention.
        Req = 3'b111; eng_d = 0; eng_l = 2; eng_data = 13'h0042;
        observe("rstptr", 0, Cmd[3:0], gap_of(0, 2, 1'b0), 13'h0042, 1'b0, -1, sa);
        Req = '0;
        idle_gap("rstptr");

        // Randomized traffic against the reference model.
        pulse_reset();
        m_last = N - 1;
        m_err  = 1'b0;
        Req    = 3'($urandom_range(1, 7));
        Cmd    = 12'($urandom);
        for (int t = 0; t < 40; t++) begin
            string nm;
            nm        = $sformatf("rand%0d", t);
            eng_d     = $urandom_range(0, 4);
            eng_l     = $urandom_range(1, 10);
            eng_never = ($urandom_range(0, 7) == 0);
            eng_data  = 13'($urandom);
            idx       = rr_pick(Req, m_last);
            m_err     = m_err | aborts(eng_d, eng_l, eng_never);
            observe(nm, idx, Cmd[4*idx +: 4], gap_of(eng_d, eng_l, eng_never),
                    aborts(eng_d, eng_l, eng_never) ? 13'h1FFF : eng_data,
                    m_err, -1, sa);
            m_last   = idx;
            Req[idx] = 1'b0;
            Req      = Req | 3'($urandom);
            if (Req == '0) Req[$urandom_range(0, N - 1)] = 1'b1;
            Cmd = 12'($urandom);
            idle_gap(nm);
        end
        Req = '0;
        repeat (5) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_arbiter.md
ADC_ARBITER -- requirements
Module: adc_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 3, number of requesters sharing the serial ADC exchange engine.
REQ-002 Parameter: TIMEOUT, default 4095, maximum Clk cycles allowed per wait phase before abort.
REQ-003 Clk  input  1  system clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Req  input  NUM_REQ  per-requester conversion request; held high until that requester's Done.
REQ-006 Cmd  input  NUM_REQ*4  per-requester 4-bit ADC command word; slice i is bits [4i+3:4i].
REQ-007 Gnt  output  NUM_REQ  one-hot grant; high from arbitration until Done.
REQ-008 Done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 Result  output  13  last captured conversion; valid in the Done cycle and held until the next Done.
REQ-010 TimeoutErr  output  1  sticky flag; set by an aborted transaction.
REQ-011 ErrClr  input  1  clears TimeoutErr.
REQ-012 ExStart  output  1  start pulse to the exchange engine.
REQ-013 ExDataIn  output  4  command to the exchange engine.
REQ-014 ExDataOut  input  13  conversion data from the exchange engine.
REQ-015 ExBusy  input  1  exchange engine busy.

Function
REQ-016 FSM states: IDLE, START, WAIT_ACK, WAIT_DONE, DELIVER.
REQ-017 IDLE: if any Req is high, select the winner round-robin, set Gnt, latch its Cmd, and go to START in the same cycle; otherwise stay in IDLE.
REQ-018 Round-robin order: the search starts at the index after the last-served requester and wraps at NUM_REQ; after reset, requester 0 has highest priority.
REQ-019 START: assert ExStart for exactly one cycle with ExDataIn = latched Cmd, then go to WAIT_ACK.
REQ-020 WAIT_ACK: wait for ExBusy=1, then go to WAIT_DONE.
REQ-021 WAIT_DONE: wait for ExBusy=0; on that cycle capture ExDataOut into Result and go to DELIVER.
REQ-022 DELIVER: pulse Done[granted] for one cycle, clear Gnt, update the last-served pointer, and return to IDLE.
REQ-023 Minimum spacing between successive grants is one IDLE cycle.
REQ-024 ExDataIn stays constant from START until return to IDLE.
REQ-025 Latency from Req rising (engine idle, no contention) to ExStart is 2 cycles.
REQ-026 Timeout: a 12-bit counter clears on entry to WAIT_ACK and again on entry to WAIT_DONE; if it reaches TIMEOUT before the exit condition, go to DELIVER with Result=13'h1FFF and set TimeoutErr.
REQ-027 If the granted Req drops mid-transaction, the transaction still completes and Done still pulses; the arbiter never cancels an in-flight exchange.
REQ-028 Requests arriving during a transaction are queued only by their level; no request edges are stored.
REQ-029 If ErrClr and a timeout set occur in the same cycle, set wins.
REQ-030 Gnt is never non-zero in IDLE.

Reset
REQ-031 Reset forces IDLE, Gnt=0, Done=0, ExStart=0, ExDataIn=0, Result=0, TimeoutErr=0, last-served pointer = NUM_REQ-1, timeout counter=0.
REQ-032 Reset mid-transaction aborts with no Done pulse; the exchange engine is reset by the same Reset net.

Structure
REQ-033 FSM state encodings and the TIMEOUT default shall reside in the shared ADC constants package.
REQ-034 Round-robin winner selection shall be a sub-module rr_select (inputs Req and last-served pointer; output one-hot winner), reusable by other arbiters.

Verification
REQ-035 Single request: Req=3'b001, Cmd0=4'h5, engine model busy 30 cycles returning 13'h0ABC -> ExStart 2 cycles after Req, ExDataIn=4'h5, Done=3'b001, Result=13'h0ABC.
REQ-036 Contention: Req=3'b111 held continuously -> grant order 0,1,2,0, each Done preceded by exactly one ExStart.
REQ-037 Wrap: last served=2, Req=3'b101 -> requester 0 is granted before requester 2.
REQ-038 Timeout: engine never asserts ExBusy -> after TIMEOUT cycles in WAIT_ACK, Done pulses with Result=13'h1FFF and TimeoutErr=1; ErrClr clears TimeoutErr.
REQ-039 Req drop: requester 1 drops Req during WAIT_DONE -> Done[1] still pulses and the next grant goes to the next requester.
REQ-040 Reset in WAIT_DONE -> next cycle IDLE, all outputs 0, no Done pulse.
